uart_fifo_gen2: RTL and testbench

- Second-generation parametrised synchronous FIFO for the UART RX/TX datapaths.
- Adds the following over the first-generation buffer:
  - occupancy count
  - programmable almost-full/almost-empty thresholds
  - sticky overflow/underflow error flags
  - synchronous flush
  - selectable read timing
- Sits between the UART receiver/transmitter shift logic and the host-side bus interface.

---
 rtl/uart_fifo_gen2.sv | 124 ++++++++++++
 tb/tb_uart_fifo_gen2.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_gen2.sv
// rtl/uart_fifo_gen2.sv - UART datapath FIFO with count, thresholds, sticky errors, flush (FWFT via UART_FIFO_FWFT_EN)
module uart_fifo_gen2 #(
    parameter int addr_width = 5,
    parameter int Data_bits  = 9,
    parameter int AF_LEVEL   = 28,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  flush,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [Data_bits-1:0]  w_data,
    input  logic                  err_clr,
    output logic [Data_bits-1:0]  r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2 ** addr_width;
    localparam logic [addr_width:0] DEPTH_C = DEPTH[addr_width:0];
    localparam logic [addr_width:0] AF_LV   = AF_LEVEL[addr_width:0];
    localparam logic [addr_width:0] AE_LV   = AE_LEVEL[addr_width:0];

    logic [Data_bits-1:0]  mem [DEPTH];

    logic [addr_width-1:0] w_ptr_q, w_ptr_d;
    logic [addr_width-1:0] r_ptr_q, r_ptr_d;
    logic [addr_width:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    // Status flags decode straight from the registered count
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_LV);
    assign almost_empty = (count_q <= AE_LV);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Accept decisions, pointer/count updates and sticky error flags
    always_comb begin
        wr_ok       = wr & ~full & ~flush;
        rd_ok       = rd & ~empty & ~flush;
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (wr_ok) w_ptr_d = w_ptr_q + 1'b1;
            if (rd_ok) r_ptr_d = r_ptr_q + 1'b1;
            if (wr_ok && !rd_ok) count_d = count_q + 1'b1;
            if (rd_ok && !wr_ok) count_d = count_q - 1'b1;
        end

        // A new error event wins over a clear in the same cycle; flush masks errors
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (!flush && wr && full)  overflow_d  = 1'b1;
        if (!flush && rd && empty) underflow_d = 1'b1;
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_ptr_q] <= w_data;
    end

    // Control state registers with asynchronous clear
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    // Head of queue falls through combinationally; zero while empty
    always_comb begin
        r_data = '0;
        if (!empty) r_data = mem[r_ptr_q];
    end
`else
    logic [Data_bits-1:0] r_data_q, r_data_d;

    // Registered read port: capture head on an accepted read, else hold
    always_comb begin
        r_data_d = r_data_q;
        if (rd_ok) r_data_d = mem[r_ptr_q];
    end

    // Read data register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_data_q <= '0;
        else        r_data_q <= r_data_d;
    end

    assign r_data = r_data_q;
`endif

endmodule

// File: tb/tb_uart_fifo_gen2.sv
// tb/tb_uart_fifo_gen2.sv - directed table-driven bench for uart_fifo_gen2
module tb_uart_fifo_gen2;

    logic       clk = 1'b0;
    logic       Reset = 1'b0;
    logic       flush = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [8:0] w_data = '0;
    logic       err_clr = 1'b0;
    logic [8:0] r_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [5:0] count;

    int errors = 0;
    int checks = 0;

    uart_fifo_gen2 dut (
        .clk(clk), .Reset(Reset), .flush(flush), .wr(wr), .rd(rd),
        .w_data(w_data), .err_clr(err_clr), .r_data(r_data),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       flush, wr, rd, err_clr;
        logic [8:0] w_data;
        logic [5:0] e_count;
        logic       e_empty, e_full, e_af, e_ae, e_ov, e_uf;
        logic       chk_rd;
        logic [8:0] e_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_stat(input string name, input logic [5:0] c, input logic e, input logic f,
                            input logic af, input logic ae, input logic ov, input logic uf);
        chk(name, {20'd0, count, empty, full, almost_full, almost_empty, overflow, underflow},
                  {20'd0, c, e, f, af, ae, ov, uf});
    endtask

    // Advance one edge; outputs are sampled 1ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [8:0] d);
        wr = 1'b1; w_data = d;
        step();
        wr = 1'b0;
    endtask

    task automatic pop_check(input string name, input logic [8:0] exp);
`ifdef UART_FIFO_FWFT_EN
        chk(name, {23'd0, r_data}, {23'd0, exp});
        rd = 1'b1;
        step();
        rd = 1'b0;
`else
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk(name, {23'd0, r_data}, {23'd0, exp});
`endif
    endtask

    task automatic clean();
        flush = 1'b1; err_clr = 1'b1;
        step();
        flush = 1'b0; err_clr = 1'b0;
    endtask

    logic [8:0] q [$];
    logic [8:0] nxt;
    logic [8:0] head;

    initial begin
        //            fl  wr  rd  ec  wdata   cnt  emp ful af ae ov uf chk rdata
        vecs[0] = '{1'b0,1'b1,1'b0,1'b0,9'h101, 6'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000};
        vecs[1] = '{1'b0,1'b1,1'b0,1'b0,9'h0AA, 6'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000};
        vecs[2] = '{1'b0,1'b1,1'b0,1'b0,9'h155, 6'd3,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000};
        vecs[3] = '{1'b0,1'b0,1'b1,1'b0,9'h000, 6'd2,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,9'h101};
        vecs[4] = '{1'b0,1'b0,1'b1,1'b0,9'h000, 6'd1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,9'h0AA};
        vecs[5] = '{1'b0,1'b0,1'b1,1'b0,9'h000, 6'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,9'h155};
        vecs[6] = '{1'b0,1'b0,1'b1,1'b0,9'h000, 6'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,9'h155};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b1,9'h000, 6'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000};
        vecs[8] = '{1'b0,1'b0,1'b1,1'b1,9'h000, 6'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,9'h000};
        vecs[9] = '{1'b0,1'b0,1'b0,1'b1,9'h000, 6'd0,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,9'h000};

        // Reset state
        #12;
        chk_stat("reset_status", 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("reset_rdata", {23'd0, r_data}, 32'd0);
        Reset = 1'b1;
        @(negedge clk);

        // Basic write/read/underflow/err_clr table
        for (int i = 0; i < 10; i++) begin
            flush = vecs[i].flush; wr = vecs[i].wr; rd = vecs[i].rd;
            err_clr = vecs[i].err_clr; w_data = vecs[i].w_data;
            step();
            flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
            chk_stat($sformatf("vec%0d_status", i), vecs[i].e_count, vecs[i].e_empty, vecs[i].e_full,
                     vecs[i].e_af, vecs[i].e_ae, vecs[i].e_ov, vecs[i].e_uf);
`ifndef UART_FIFO_FWFT_EN
            if (vecs[i].chk_rd)
                chk($sformatf("vec%0d_rdata", i), {23'd0, r_data}, {23'd0, vecs[i].e_rdata});
`endif
        end

        // Fill to full, thresholds, overflow, err_clr, read+write while full
        clean();
        for (int k = 1; k <= 32; k++) begin
            push(9'(k - 1));
            chk_stat($sformatf("fill%0d", k), 6'(k), 1'b0, (k == 32), (k >= 28), (k <= 4), 1'b0, 1'b0);
        end
        push(9'h1FF);
        chk_stat("overflow_set", 6'd32, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk_stat("overflow_clr", 6'd32, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wr = 1'b1; rd = 1'b1; w_data = 9'h1EE; step(); wr = 1'b0; rd = 1'b0;
        chk_stat("full_rdwr", 6'd31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`ifndef UART_FIFO_FWFT_EN
        chk("full_rdwr_data", {23'd0, r_data}, 32'd0);
`endif
        pop_check("full_second_word", 9'd1);

        // Simultaneous rd/wr from empty
        clean();
        wr = 1'b1; rd = 1'b1; w_data = 9'h1F0; step(); wr = 1'b0; rd = 1'b0;
        chk_stat("empty_rdwr", 6'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        pop_check("empty_rdwr_data", 9'h1F0);

        // Steady state at count 10 with wrapping pointers
        clean();
        q.delete();
        nxt = 9'h100;
        for (int k = 0; k < 10; k++) begin
            push(nxt); q.push_back(nxt); nxt = nxt + 9'd1;
        end
        chk("steady_fill", {26'd0, count}, 32'd10);
        for (int k = 0; k < 50; k++) begin
            head = q.pop_front();
            q.push_back(nxt);
`ifdef UART_FIFO_FWFT_EN
            chk($sformatf("steady%0d_data", k), {23'd0, r_data}, {23'd0, head});
`endif
            wr = 1'b1; rd = 1'b1; w_data = nxt;
            step();
            wr = 1'b0; rd = 1'b0;
            nxt = nxt + 9'd1;
`ifndef UART_FIFO_FWFT_EN
            chk($sformatf("steady%0d_data", k), {23'd0, r_data}, {23'd0, head});
`endif
            chk($sformatf("steady%0d_count", k), {26'd0, count}, 32'd10);
        end
        chk_stat("steady_end", 6'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Flush beats a same-cycle write; error flags untouched
        clean();
        rd = 1'b1; step(); rd = 1'b0;
        for (int k = 0; k < 7; k++) push(9'(k + 3));
        chk_stat("pre_flush", 6'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        flush = 1'b1; wr = 1'b1; w_data = 9'h0FF; step(); flush = 1'b0; wr = 1'b0;
        chk_stat("flush_wr", 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Asynchronous reset mid-burst
        clean();
        for (int k = 0; k < 5; k++) push(9'h040 + 9'(k));
        rd = 1'b1; step(); rd = 1'b0;
        wr = 1'b1; w_data = 9'h077;
        rd = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        chk_stat("async_reset_status", 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("async_reset_rdata", {23'd0, r_data}, 32'd0);
        wr = 1'b0; rd = 1'b0;
        step();
        #2;
        Reset = 1'b1;
        step();
        push(9'h033);
        chk("post_reset_count", {26'd0, count}, 32'd1);
        pop_check("post_reset_data", 9'h033);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
